bcd_counter_display: RTL and testbench

BCD_COUNTER_DISPLAY -- requirements
Module: bcd_counter_display

---
 rtl/bcd_counter_display.sv | 101 ++++++++++
 tb/tb_bcd_counter_display.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_display.sv
// Two-digit BCD up/down counter stepped by a prescaler, with registered 7-segment decode.
// Optional LEADING_ZERO_BLANK_EN blanks the tens display while tens is zero.
module bcd_counter_display #(
    parameter int TICK_CYCLES    = 25_000_000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       hold,
    input  logic       up_dn,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [6:0] seg_ones,
    output logic [6:0] seg_tens,
    output logic       tick
);

    localparam int              PW   = $clog2(TICK_CYCLES);
    localparam logic [PW-1:0]   LAST = PW'(TICK_CYCLES - 1);
    localparam logic [6:0]      BLANK = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b1000000;
            4'd1:    p = 7'b1111001;
            4'd2:    p = 7'b0100100;
            4'd3:    p = 7'b0110000;
            4'd4:    p = 7'b0011001;
            4'd5:    p = 7'b0010010;
            4'd6:    p = 7'b0000010;
            4'd7:    p = 7'b1111000;
            4'd8:    p = 7'b0000000;
            4'd9:    p = 7'b0010000;
            default: p = 7'b1111111;
        endcase
        return SEG_ACTIVE_LOW ? p : ~p;
    endfunction

    function automatic logic [6:0] seg7_tens(input logic [3:0] d);
`ifdef LEADING_ZERO_BLANK_EN
        return (d == 4'd0) ? BLANK : seg7(d);
`else
        return seg7(d);
`endif
    endfunction

    logic [PW-1:0] presc;
    logic [3:0]    ones_nx, tens_nx;

    // Digit step arithmetic; only committed on a step cycle.
    always_comb begin
        ones_nx = ones;
        tens_nx = tens;
        if (up_dn) begin
            if (ones == 4'd9) begin
                ones_nx = 4'd0;
                tens_nx = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
            end else begin
                ones_nx = ones + 4'd1;
            end
        end else begin
            if (ones == 4'd0) begin
                ones_nx = 4'd9;
                tens_nx = (tens == 4'd0) ? 4'd9 : tens - 4'd1;
            end else begin
                ones_nx = ones - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc    <= '0;
            ones     <= 4'd0;
            tens     <= 4'd0;
            tick     <= 1'b0;
            seg_ones <= seg7(4'd0);
            seg_tens <= seg7_tens(4'd0);
        end else begin
            tick     <= 1'b0;
            // Decode from the current digit registers: one cycle behind them.
            seg_ones <= seg7(ones);
            seg_tens <= seg7_tens(tens);
            if (!start) begin
                presc <= '0;
            end else if (!hold) begin
                if (presc == LAST) begin
                    presc <= '0;
                    ones  <= ones_nx;
                    tens  <= tens_nx;
                    tick  <= 1'b1;
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_counter_display.sv
// Directed self-checking bench for bcd_counter_display with TICK_CYCLES=4, active-low segments.
module tb_bcd_counter_display;

    logic       clk = 1'b0;
    logic       rst, start, hold, up_dn;
    logic [3:0] ones, tens;
    logic [6:0] seg_ones, seg_tens;
    logic       tick;

    int tests = 0;
    int fails = 0;
    int m     = 0;
    int hits;

    localparam logic [6:0] P0 = 7'b1000000;
    localparam logic [6:0] P1 = 7'b1111001;
    localparam logic [6:0] P9 = 7'b0010000;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] TZ = 7'b1111111;
`else
    localparam logic [6:0] TZ = P0;
`endif

    bcd_counter_display #(.TICK_CYCLES(4), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold), .up_dn(up_dn),
        .ones(ones), .tens(tens), .seg_ones(seg_ones), .seg_tens(seg_tens), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cyc_count(input int n, output int h);
        h = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (tick === 1'b1) h++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    // One full interval from prescaler 0: the step lands on the 4th edge.
    task automatic step_chk(input string tag);
        cyc(4);
        chk({tag, "_tick"}, 32'(tick), 32'd1);
        chk({tag, "_dig"}, {24'd0, tens, ones}, {24'd0, bcd(m)});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; hold = 1'b0; up_dn = 1'b1;
        cyc(2);
        chk("rst_ones", 32'(ones), 32'd0);
        chk("rst_tens", 32'(tens), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_seg_ones", 32'(seg_ones), 32'(P0));
        chk("rst_seg_tens", 32'(seg_tens), 32'(TZ));

        rst = 1'b0;
        cyc_count(20, hits);
        chk("idle_no_tick", 32'(hits), 32'd0);
        chk("idle_dig", {24'd0, tens, ones}, 32'd0);
        chk("idle_seg_ones", 32'(seg_ones), 32'(P0));

        // First step exactly 4 edges after start
        start = 1'b1;
        cyc(3);
        chk("first_pre_tick", 32'(tick), 32'd0);
        cyc(1); m = 1;
        chk("first_tick", 32'(tick), 32'd1);
        chk("first_dig", {24'd0, tens, ones}, {24'd0, bcd(m)});
        chk("first_seg_ones_lag", 32'(seg_ones), 32'(P0));
        cyc(1);
        chk("first_tick_pulse", 32'(tick), 32'd0);
        chk("first_seg_ones", 32'(seg_ones), 32'(P1));
        cyc(3); m = 2;
        chk("second_tick", 32'(tick), 32'd1);
        for (int k = 3; k <= 9; k++) begin
            m = k;
            step_chk("up");
        end
        // 09 -> 10: tens display follows one cycle later
        cyc(4); m = 10;
        chk("ten_tick", 32'(tick), 32'd1);
        chk("ten_dig", {24'd0, tens, ones}, 32'h10);
        chk("ten_seg_tens_lag", 32'(seg_tens), 32'(TZ));
        cyc(1);
        chk("ten_seg_tens", 32'(seg_tens), 32'(P1));
        chk("ten_seg_ones", 32'(seg_ones), 32'(P0));
        cyc(3); m = 11;
        chk("eleven_dig", {24'd0, tens, ones}, {24'd0, bcd(m)});

        // Run up to 99, then wrap to 00
        while (m < 99) begin
            m++;
            step_chk("run_up");
        end
        m = 0;
        step_chk("wrap_up");

        // Down from 00 wraps to 99
        up_dn = 1'b0;
        m = 99;
        step_chk("wrap_dn");
        cyc(1);
        chk("wrap_dn_seg_ones", 32'(seg_ones), 32'(P9));
        chk("wrap_dn_seg_tens", 32'(seg_tens), 32'(P9));
        cyc(3); m = 98;
        chk("dn_dig", {24'd0, tens, ones}, {24'd0, bcd(m)});

        // Hold at prescaler 2
        cyc(2);
        hold = 1'b1;
        cyc_count(10, hits);
        chk("hold_no_tick", 32'(hits), 32'd0);
        chk("hold_dig", {24'd0, tens, ones}, {24'd0, bcd(m)});
        hold = 1'b0;
        cyc(1);
        chk("unhold_pre", 32'(tick), 32'd0);
        cyc(1); m = 97;
        chk("unhold_tick", 32'(tick), 32'd1);
        chk("unhold_dig", {24'd0, tens, ones}, {24'd0, bcd(m)});

        // Direction change mid-interval only affects the next step
        up_dn = 1'b1;
        cyc_count(3, hits);
        chk("dir_no_glitch", 32'(hits), 32'd0);
        chk("dir_dig_stable", {24'd0, tens, ones}, {24'd0, bcd(m)});
        cyc(1); m = 98;
        chk("dir_step", {24'd0, tens, ones}, {24'd0, bcd(m)});

        // Dropping start clears the prescaler
        cyc(2);
        start = 1'b0;
        cyc(3);
        start = 1'b1;
        cyc_count(3, hits);
        chk("restart_no_tick", 32'(hits), 32'd0);
        cyc(1); m = 99;
        chk("restart_tick", 32'(tick), 32'd1);
        chk("restart_dig", {24'd0, tens, ones}, {24'd0, bcd(m)});

        // Count to 37 and reset on its tick cycle
        while (m != 37) begin
            m = (m + 1) % 100;
            step_chk("to37");
        end
        rst = 1'b1;
        cyc(1);
        chk("mid_rst_dig", {24'd0, tens, ones}, 32'd0);
        chk("mid_rst_tick", 32'(tick), 32'd0);
        chk("mid_rst_seg_ones", 32'(seg_ones), 32'(P0));
        chk("mid_rst_seg_tens", 32'(seg_tens), 32'(TZ));
        rst = 1'b0;
        cyc_count(3, hits);
        chk("post_rst_no_tick", 32'(hits), 32'd0);
        cyc(1);
        chk("post_rst_tick", 32'(tick), 32'd1);
        chk("post_rst_dig", {24'd0, tens, ones}, 32'h01);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, observed running expected done");
        $fatal(1, "timeout");
    end

endmodule
